// File: rtl/serial_rx.sv
// UART receiver with an oversampling front end, a receive FIFO and a two-register read port (DATA/STATUS).
// Define SERIAL_RX_PARITY_EN for 8E1 framing with parity checking; otherwise the frame is 8N1.
module serial_rx #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clock,
  input  logic        clrn,
  input  logic        rx,
  input  logic        sel,
  input  logic        re,
  input  logic [31:0] addr,
  output logic [31:0] dout,
  output logic        irq
);

  localparam int DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PW      = AW + 1;

  localparam logic [3:0] TC_MID  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] TC_LAST = 4'(OVERSAMPLE - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
`ifdef SERIAL_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif

  // Only addr[2] selects a register; the remaining bits are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:3], addr[1:0]};

  // ---------------------------------------------------------------
  // rx synchronizer, idle-high so reset never looks like a start bit
  // ---------------------------------------------------------------
  logic [1:0] sync_reg;
  logic       rx_s;

  always_ff @(posedge clock) begin
    if (!clrn) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], rx};
    end
  end

  assign rx_s = sync_reg[1];

  // ---------------------------------------------------------------
  // Oversample tick generator
  // ---------------------------------------------------------------
  logic [2:0]    state_reg;
  logic [3:0]    tc_reg;
  logic [2:0]    bit_cnt_reg;
  logic [7:0]    shift_reg;
  logic          armed_reg;
  logic [DW-1:0] div_cnt_reg;
  logic          tick;
  logic          start_det;

  assign tick      = (div_cnt_reg == DW'(DIV - 1));
  assign start_det = (state_reg == IDLE) && armed_reg && !rx_s;

  always_ff @(posedge clock) begin
    if (!clrn) begin
      div_cnt_reg <= '0;
    end else if (start_det || tick) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + DW'(1);
    end
  end

  // ---------------------------------------------------------------
  // Frame events derived from the current FSM position
  // ---------------------------------------------------------------
  logic sample_point;
  logic stop_sample;
  logic push_req;
  logic fe_set;
  logic pe_set;

  assign sample_point = tick && (tc_reg == TC_LAST);
  assign stop_sample  = (state_reg == STOP) && sample_point;
  assign fe_set       = stop_sample && !rx_s;

`ifdef SERIAL_RX_PARITY_EN
  logic pe_pend_reg;
  // Even parity: the parity bit must equal the XOR of the data bits.
  assign pe_set   = (state_reg == PARITY) && sample_point && (rx_s != ^shift_reg);
  assign push_req = stop_sample && rx_s && !pe_pend_reg;
`else
  assign pe_set   = 1'b0;
  assign push_req = stop_sample && rx_s;
`endif

  // ---------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!clrn) begin
      state_reg   <= IDLE;
      tc_reg      <= 4'd0;
      bit_cnt_reg <= 3'd0;
      shift_reg   <= 8'd0;
      armed_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (rx_s) begin
            armed_reg <= 1'b1;
          end
          if (start_det) begin
            state_reg <= START;
            tc_reg    <= 4'd0;
          end
        end
        START: begin
          if (tick) begin
            if (tc_reg == TC_MID) begin
              tc_reg <= 4'd0;
              if (!rx_s) begin
                state_reg   <= DATA;
                bit_cnt_reg <= 3'd0;
              end else begin
                state_reg <= IDLE;
              end
            end else begin
              tc_reg <= tc_reg + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (tc_reg == TC_LAST) begin
              tc_reg      <= 4'd0;
              shift_reg   <= {rx_s, shift_reg[7:1]};
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              if (bit_cnt_reg == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
                state_reg <= PARITY;
`else
                state_reg <= STOP;
`endif
              end
            end else begin
              tc_reg <= tc_reg + 4'd1;
            end
          end
        end
`ifdef SERIAL_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            if (tc_reg == TC_LAST) begin
              tc_reg    <= 4'd0;
              state_reg <= STOP;
            end else begin
              tc_reg <= tc_reg + 4'd1;
            end
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (tc_reg == TC_LAST) begin
              tc_reg    <= 4'd0;
              state_reg <= IDLE;
              // A low stop bit means the line may still be in break; wait for high before re-arming.
              if (!rx_s) begin
                armed_reg <= 1'b0;
              end
            end else begin
              tc_reg <= tc_reg + 4'd1;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          tc_reg    <= 4'd0;
        end
      endcase
    end
  end

`ifdef SERIAL_RX_PARITY_EN
  always_ff @(posedge clock) begin
    if (!clrn) begin
      pe_pend_reg <= 1'b0;
    end else if (state_reg == START) begin
      pe_pend_reg <= 1'b0;
    end else if (pe_set) begin
      pe_pend_reg <= 1'b1;
    end
  end
`endif

  // ---------------------------------------------------------------
  // Bus access edge detection
  // ---------------------------------------------------------------
  logic pop_req;
  logic pop_req_d_reg;
  logic st_req;
  logic st_req_d_reg;
  logic st_clr;

  assign pop_req = sel && re && !addr[2];
  assign st_req  = sel && re && addr[2];
  assign st_clr  = st_req && !st_req_d_reg;

  always_ff @(posedge clock) begin
    if (!clrn) begin
      pop_req_d_reg <= 1'b0;
      st_req_d_reg  <= 1'b0;
    end else begin
      pop_req_d_reg <= pop_req;
      st_req_d_reg  <= st_req;
    end
  end

  // ---------------------------------------------------------------
  // Receive FIFO; pointers carry one extra wrap bit
  // ---------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_next;
  logic [PW-1:0] rd_ptr_next;
  logic [PW-1:0] count;
  logic          empty;
  logic          full;
  logic          pop;
  logic          do_push;
  logic          ov_set;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[PW-1] != rd_ptr_reg[PW-1]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign count   = wr_ptr_reg - rd_ptr_reg;
  assign pop     = pop_req && !pop_req_d_reg && !empty;
  // A same-cycle pop frees the slot before the push is considered.
  assign do_push = push_req && (!full || pop);
  assign ov_set  = push_req && full && !pop;

  assign wr_ptr_next = wr_ptr_reg + {{(PW-1){1'b0}}, do_push};
  assign rd_ptr_next = rd_ptr_reg + {{(PW-1){1'b0}}, pop};

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= shift_reg;
    end
  end

  always_ff @(posedge clock) begin
    if (!clrn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      irq        <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      irq        <= (wr_ptr_next != rd_ptr_next);
    end
  end

  // ---------------------------------------------------------------
  // Sticky status flags; a new event outranks a simultaneous clear
  // ---------------------------------------------------------------
  logic ov_reg;
  logic fe_reg;
  logic pe_reg;

  always_ff @(posedge clock) begin
    if (!clrn) begin
      ov_reg <= 1'b0;
      fe_reg <= 1'b0;
      pe_reg <= 1'b0;
    end else begin
      ov_reg <= ov_set || (ov_reg && !st_clr);
      fe_reg <= fe_set || (fe_reg && !st_clr);
      pe_reg <= pe_set || (pe_reg && !st_clr);
    end
  end

  // ---------------------------------------------------------------
  // Read data mux
  // ---------------------------------------------------------------
  always_comb begin
    dout = 32'd0;
    if (addr[2]) begin
      dout[0]    = !empty;
      dout[1]    = ov_reg;
      dout[2]    = fe_reg;
      dout[3]    = pe_reg;
      dout[15:8] = 8'(count);
    end else if (!empty) begin
      dout[7:0] = mem[rd_ptr_reg[AW-1:0]];
    end
  end

endmodule

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx at 16 clocks per bit: a table of single frames plus hand sequences
// for glitches, overflow, framing error, mid-frame reset and (with SERIAL_RX_PARITY_EN) parity.
module tb_serial_rx;

  logic        clock;
  logic        clrn;
  logic        rx;
  logic        sel;
  logic        re;
  logic [31:0] addr;
  logic [31:0] dout;
  logic        irq;

  int checks = 0;
  int passes = 0;
  int lat0   = 0;

  serial_rx #(
    .CLK_HZ(1600),
    .BAUD(100),
    .OVERSAMPLE(16),
    .FIFO_DEPTH(16)
  ) dut (
    .clock(clock),
    .clrn(clrn),
    .rx(rx),
    .sel(sel),
    .re(re),
    .addr(addr),
    .dout(dout),
    .irq(irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  data;
    logic [31:0] exp_status;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // One bus read: asserted for a single rising edge, sampled mid-cycle.
  task automatic bus_read(input logic st, output logic [31:0] d);
    @(negedge clock);
    sel  = 1'b1;
    re   = 1'b1;
    addr = st ? 32'h4 : 32'h0;
    #1 d = dout;
    $display("read %s -> 0x%08h", st ? "STATUS" : "DATA  ", d);
    @(negedge clock);
    sel  = 1'b0;
    re   = 1'b0;
    addr = 32'h0;
  endtask

  task automatic read_check(input string name, input logic st, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(st, d);
    check(name, d, exp);
  endtask

  // Drives one frame starting at the current time (call at a falling edge).
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip, input int tail_low);
    rx = 1'b0;
    repeat (16) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (16) @(negedge clock);
    end
`ifdef SERIAL_RX_PARITY_EN
    rx = (^d) ^ par_flip;
    repeat (16) @(negedge clock);
`endif
    rx = stop;
    repeat (16 + tail_low) @(negedge clock);
    rx = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic measure_latency(output int n);
    n = 0;
    while (irq !== 1'b1 && n < 400) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    clrn = 1'b0;
    @(negedge clock);
    clrn = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    int lat;

    vecs[0] = '{data: 8'h55, exp_status: 32'h0000_0101, exp_data: 32'h0000_0055};
    vecs[1] = '{data: 8'h00, exp_status: 32'h0000_0101, exp_data: 32'h0000_0000};
    vecs[2] = '{data: 8'hFF, exp_status: 32'h0000_0101, exp_data: 32'h0000_00FF};
    vecs[3] = '{data: 8'hA5, exp_status: 32'h0000_0101, exp_data: 32'h0000_00A5};
    vecs[4] = '{data: 8'h80, exp_status: 32'h0000_0101, exp_data: 32'h0000_0080};
    vecs[5] = '{data: 8'h01, exp_status: 32'h0000_0101, exp_data: 32'h0000_0001};

    clrn = 1'b0;
    rx   = 1'b1;
    sel  = 1'b0;
    re   = 1'b0;
    addr = 32'h0;
    repeat (3) @(negedge clock);
    clrn = 1'b1;
    repeat (8) @(negedge clock);

    // Reset state
    check("reset_irq", {31'b0, irq}, 32'h0);
    read_check("reset_status", 1'b1, 32'h0);
    read_check("reset_data", 1'b0, 32'h0);

    // Table of single frames
    for (int v = 0; v < 6; v++) begin
      @(negedge clock);
      fork
        send_frame(vecs[v].data, 1'b1, 1'b0, 0);
        measure_latency(lat);
      join
      if (v == 0) lat0 = lat;
      $display("frame 0x%02h irq latency %0d cycles", vecs[v].data, lat);
      check("latency", {31'b0, (lat >= 150 && lat <= 160)}, 32'h1);
      check("irq_set", {31'b0, irq}, 32'h1);
      read_check("frame_status", 1'b1, vecs[v].exp_status);
      read_check("frame_data", 1'b0, vecs[v].exp_data);
      read_check("frame_status_after", 1'b1, 32'h0);
      check("irq_clear", {31'b0, irq}, 32'h0);
    end

    // Short low glitch is not a start bit
    @(negedge clock);
    rx = 1'b0;
    repeat (4) @(negedge clock);
    rx = 1'b1;
    repeat (40) @(negedge clock);
    check("glitch_irq", {31'b0, irq}, 32'h0);
    read_check("glitch_status", 1'b1, 32'h0);

    // Overflow: 17 frames, no reads
    for (int i = 0; i < 17; i++) begin
      @(negedge clock);
      send_frame(8'(i), 1'b1, 1'b0, 0);
    end
    read_check("ovf_status", 1'b1, 32'h0000_1003);
    read_check("ovf_status_cleared", 1'b1, 32'h0000_1001);
    for (int i = 0; i < 16; i++) begin
      read_check("ovf_data", 1'b0, 32'(i));
    end
    read_check("ovf_status_empty", 1'b1, 32'h0);
    read_check("pop_on_empty", 1'b0, 32'h0);
    read_check("pop_on_empty_status", 1'b1, 32'h0);

    // Full FIFO: pop lands on the same edge as the push
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      send_frame(8'(i), 1'b1, 1'b0, 0);
    end
    @(negedge clock);
    fork
      send_frame(8'h20, 1'b1, 1'b0, 0);
      begin
        repeat (lat0 - 2) @(negedge clock);
        bus_read(1'b0, d);
      end
    join
    check("pushpop_data", d, 32'h0);
    read_check("pushpop_status", 1'b1, 32'h0000_1001);
    for (int i = 1; i < 16; i++) begin
      read_check("pushpop_drain", 1'b0, 32'(i));
    end
    read_check("pushpop_last", 1'b0, 32'h20);
    read_check("pushpop_empty", 1'b1, 32'h0);

    // Multi-cycle read pops once
    @(negedge clock);
    send_frame(8'h61, 1'b1, 1'b0, 0);
    @(negedge clock);
    send_frame(8'h62, 1'b1, 1'b0, 0);
    @(negedge clock);
    sel = 1'b1; re = 1'b1; addr = 32'h0;
    repeat (3) @(negedge clock);
    sel = 1'b0; re = 1'b0;
    read_check("long_read_status", 1'b1, 32'h0000_0101);
    read_check("long_read_data", 1'b0, 32'h62);

    // Framing error, line held low, then a good frame
    @(negedge clock);
    send_frame(8'hA3, 1'b0, 1'b0, 32);
    @(negedge clock);
    send_frame(8'h11, 1'b1, 1'b0, 0);
    read_check("fe_status", 1'b1, 32'h0000_0105);
    read_check("fe_data", 1'b0, 32'h11);
    read_check("fe_cleared", 1'b1, 32'h0);

    // Reset in the middle of a frame
    @(negedge clock);
    send_frame(8'h77, 1'b1, 1'b0, 0);
    @(negedge clock);
    rx = 1'b0;
    repeat (32) @(negedge clock);
    rx = 1'b1;
    repeat (28) @(negedge clock);
    do_reset();
    rx = 1'b1;
    #1;
    check("midreset_irq", {31'b0, irq}, 32'h0);
    read_check("midreset_status", 1'b1, 32'h0);
    repeat (32) @(negedge clock);
    send_frame(8'h3C, 1'b1, 1'b0, 0);
    read_check("after_reset_status", 1'b1, 32'h0000_0101);
    read_check("after_reset_data", 1'b0, 32'h3C);

`ifdef SERIAL_RX_PARITY_EN
    // Parity error drops the byte
    @(negedge clock);
    send_frame(8'h07, 1'b1, 1'b1, 0);
    check("pe_irq", {31'b0, irq}, 32'h0);
    read_check("pe_status", 1'b1, 32'h0000_0008);
    read_check("pe_cleared", 1'b1, 32'h0);
    @(negedge clock);
    send_frame(8'h07, 1'b1, 1'b0, 0);
    read_check("par_ok_status", 1'b1, 32'h0000_0101);
    read_check("par_ok_data", 1'b0, 32'h07);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
